countdown_timer_ctrl: RTL

Front-panel controller for the countdown timer datapath. It turns debounced key pulses into the timer's `load` and `clock_en` controls, and holds the editable BCD preset (hh:mm:ss) that drives the timer's preset inputs. It also gates the buzzer for a bounded time after the timer rings. It sits between the key debouncers and `count_down_timer`, and runs on the same 1 kHz system clock.

---
 rtl/countdown_timer_ctrl_pkg.sv | 22 ++
 rtl/countdown_timer_ctrl_bcd_wrap_inc.sv | 19 +
 rtl/countdown_timer_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_ctrl_pkg.sv
// Shared types and constants for the countdown timer front-panel controller.
package countdown_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SET   = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_ALARM = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    FIELD_NONE   = 2'd0,
    FIELD_HOUR   = 2'd1,
    FIELD_MINUTE = 2'd2,
    FIELD_SECOND = 2'd3
  } field_e;

  localparam logic [7:0] BCD_MAX_HOUR    = 8'h23;
  localparam logic [7:0] BCD_MAX_MIN_SEC = 8'h59;

endpackage

// File: rtl/countdown_timer_ctrl_bcd_wrap_inc.sv
// Combinational two-digit BCD increment that wraps to 00 after max_value.
module bcd_wrap_inc (
  input  logic [7:0] value,
  input  logic [7:0] max_value,
  output logic [7:0] result
);

  always_comb begin
    result = '0;
    if (value != max_value) begin
      if (value[3:0] == 4'd9) begin
        result = {value[7:4] + 4'd1, 4'd0};
      end else begin
        result = {value[7:4], value[3:0] + 4'd1};
      end
    end
  end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Front-panel FSM: key handling, editable BCD preset, timer load/enable and bounded buzzer.
module countdown_timer_ctrl
  import countdown_ctrl_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 1000,
  parameter int unsigned ALARM_SEC = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_start,
  input  logic       key_reset,
  input  logic       key_set,
  input  logic       key_inc,
  input  logic       ring_in,
  output logic       load,
  output logic       clock_en,
  output logic [7:0] preset_hour_bcd,
  output logic [7:0] preset_minute_bcd,
  output logic [7:0] preset_second_bcd,
  output logic [1:0] set_field,
  output logic       buzzer,
  output logic [2:0] state_out
);

  localparam int unsigned      DIV_W      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_HZ - 1);
  localparam logic [7:0]       ALARM_LAST = 8'(ALARM_SEC - 1);

  state_e           state_q, state_d;
  field_e           field_q, field_d;
  logic [7:0]       hour_q, hour_d, minute_q, minute_d, second_q, second_d;
  logic             load_q, load_d, load_prev_q;
  logic             clock_en_q, clock_en_d, buzzer_q, buzzer_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       alarm_q, alarm_d;

  logic [7:0] inc_value, inc_max, inc_result;
  logic       preset_zero, tick, ring_guard, any_key;

  always_comb begin
    case (field_q)
      FIELD_HOUR: begin
        inc_value = hour_q;
        inc_max   = BCD_MAX_HOUR;
      end
      FIELD_MINUTE: begin
        inc_value = minute_q;
        inc_max   = BCD_MAX_MIN_SEC;
      end
      default: begin
        inc_value = second_q;
        inc_max   = BCD_MAX_MIN_SEC;
      end
    endcase
  end

  bcd_wrap_inc u_bcd_inc (
    .value     (inc_value),
    .max_value (inc_max),
    .result    (inc_result)
  );

  assign preset_zero = ((hour_q | minute_q | second_q) == 8'h00);
  assign tick        = (div_q == DIV_LAST);
  // ring is still stale from the previous count while the timer absorbs a load
  assign ring_guard  = load_q | load_prev_q;
  assign any_key     = key_start | key_reset | key_set | key_inc;

  always_comb begin
    state_d  = state_q;
    field_d  = field_q;
    hour_d   = hour_q;
    minute_d = minute_q;
    second_d = second_q;
    load_d   = 1'b0;
    div_d    = tick ? '0 : div_q + DIV_W'(1);
    alarm_d  = alarm_q;

    unique case (state_q)
      ST_IDLE: begin
        if (key_reset) begin
          load_d = 1'b1;
        end else if (key_start) begin
          if (!preset_zero) begin
            load_d  = 1'b1;
            state_d = ST_RUN;
          end
        end else if (key_set) begin
          state_d = ST_SET;
          field_d = FIELD_HOUR;
        end
      end
      ST_SET: begin
        if (key_reset) begin
          hour_d   = '0;
          minute_d = '0;
          second_d = '0;
        end else if (key_start) begin
          load_d  = 1'b1;
          field_d = FIELD_NONE;
          state_d = preset_zero ? ST_IDLE : ST_RUN;
        end else if (key_set) begin
          case (field_q)
            FIELD_HOUR:   field_d = FIELD_MINUTE;
            FIELD_MINUTE: field_d = FIELD_SECOND;
            default: begin
              field_d = FIELD_NONE;
              state_d = ST_IDLE;
              load_d  = 1'b1;
            end
          endcase
        end else if (key_inc) begin
          case (field_q)
            FIELD_HOUR:   hour_d   = inc_result;
            FIELD_MINUTE: minute_d = inc_result;
            FIELD_SECOND: second_d = inc_result;
            default:      ;
          endcase
        end
      end
      ST_RUN: begin
        if (key_reset) begin
          load_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (key_start) begin
          state_d = ST_PAUSE;
        end else if (ring_in && !ring_guard) begin
          state_d = ST_ALARM;
          div_d   = '0;
          alarm_d = '0;
        end
      end
      ST_PAUSE: begin
        if (key_reset) begin
          load_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (key_start) begin
          state_d = ST_RUN;
        end
      end
      ST_ALARM: begin
        if (any_key || (tick && alarm_q == ALARM_LAST)) begin
          load_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (tick) begin
          alarm_d = alarm_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    clock_en_d = (state_d == ST_RUN) && !load_d;
    buzzer_d   = (state_d == ST_ALARM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      field_q     <= FIELD_NONE;
      hour_q      <= '0;
      minute_q    <= '0;
      second_q    <= '0;
      load_q      <= 1'b0;
      load_prev_q <= 1'b0;
      clock_en_q  <= 1'b0;
      buzzer_q    <= 1'b0;
      div_q       <= '0;
      alarm_q     <= '0;
    end else begin
      state_q     <= state_d;
      field_q     <= field_d;
      hour_q      <= hour_d;
      minute_q    <= minute_d;
      second_q    <= second_d;
      load_q      <= load_d;
      load_prev_q <= load_q;
      clock_en_q  <= clock_en_d;
      buzzer_q    <= buzzer_d;
      div_q       <= div_d;
      alarm_q     <= alarm_d;
    end
  end

  assign load              = load_q;
  assign clock_en          = clock_en_q;
  assign buzzer            = buzzer_q;
  assign set_field         = field_q;
  assign state_out         = state_q;
  assign preset_hour_bcd   = hour_q;
  assign preset_minute_bcd = minute_q;
  assign preset_second_bcd = second_q;

endmodule
